// File: rtl/mux_rr_stream_if.sv
// Stream bundle between N producers, the multiplexer and a single consumer.
//   in_valid  : per-channel valid, bit i = channel i
//   in_data   : channel i data at [i*WIDTH +: WIDTH]
//   in_ready  : per-channel ready back to the producers
//   out_valid : registered output valid
//   out_data  : registered output data
//   out_ch    : channel id of the beat in out_data
//   out_ready : consumer ready
// The slave modport is the multiplexer's view; master is the producer/consumer side.
interface mux_rr_stream_if #(
   parameter int WIDTH = 16,
   parameter int NCH   = 4
);
   localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]       in_valid;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/mux_rr_stream.sv
// N-channel WIDTH-bit registered stream multiplexer.
// Selects one producer per cycle either by an external select (fixed mode) or
// by round-robin arbitration, and passes the beat through a one-stage output
// register with valid/ready handshaking on both sides.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   rr_mode : 0 = fixed select via sel, 1 = round-robin
//   sel     : channel passed in fixed mode (values >= NCH grant nothing)
//   bus     : stream bundle (slave modport), see mux_rr_stream_if
module mux_rr_stream #(
   parameter int WIDTH = 16,
   parameter int NCH   = 4,
   localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rr_mode,
   input  logic [SELW-1:0] sel,
   mux_rr_stream_if.slave  bus
);
   localparam int unsigned     NCHU    = NCH;
   localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [SELW-1:0]  out_ch_q;
   logic [SELW-1:0]  ptr_q;

   logic             load;
   logic             gnt_vld;
   logic [SELW-1:0]  gnt;
   logic [WIDTH-1:0] gnt_data;

   // Output register can take a new beat when empty or being drained.
   assign load = !out_valid_q || bus.out_ready;

   // Round-robin scan starts at ptr and wraps modulo NCH, so non-power-of-two
   // channel counts never alias onto a missing channel.
   always_comb begin : grant_sel
      int unsigned idx;
      logic [SELW-1:0] cand;
      gnt_vld = 1'b0;
      gnt     = '0;
      idx     = 0;
      cand    = '0;
      if (rr_mode) begin
         for (int unsigned k = 0; k < NCHU; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NCHU) idx = idx - NCHU;
            cand = idx[SELW-1:0];
            if (!gnt_vld && bus.in_valid[cand]) begin
               gnt_vld = 1'b1;
               gnt     = cand;
            end
         end
      end else if (32'(sel) < NCHU && bus.in_valid[sel]) begin
         gnt_vld = 1'b1;
         gnt     = sel;
      end
   end

   always_comb begin : data_sel
      gnt_data = '0;
      for (int unsigned i = 0; i < NCHU; i++) begin
         if (gnt == SELW'(i)) gnt_data = bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin : ready_gen
      bus.in_ready = '0;
      if (load && gnt_vld) bus.in_ready[gnt] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else if (load) begin
         if (gnt_vld) begin
            out_valid_q <= 1'b1;
            out_data_q  <= gnt_data;
            out_ch_q    <= gnt;
            if (rr_mode) ptr_q <= (gnt == LAST_CH) ? '0 : gnt + 1'b1;
         end else begin
            // Nothing granted: drop valid but keep the last data/channel.
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
endmodule
